// File: rtl/prod_divider_seq.sv
`timescale 1ns/1ps
// Sequential restoring divider that inverts the 8-bit multipliers: a DW-bit product divided
// by a VW-bit operand, one bit of quotient per cycle, valid/ready on both sides.
module prod_divider_seq #(
    parameter int DW = 17,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_r;
    logic [DW-1:0] q_r;
    logic [VW-1:0] d_r;
    logic [VW-1:0] r_r;
    logic [CW-1:0] cnt_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [DW-1:0] quotient_r;
    logic [VW-1:0] remainder_r;
    logic          dbz_r;

    logic [VW:0]   r_shift_s;
    logic [VW:0]   r_next_s;
    logic          ge_s;
    logic [DW-1:0] q_next_s;

    // One restoring step; the partial remainder stays below D, so VW+1 bits hold the shifted value.
    always_comb begin
        r_shift_s = {r_r, q_r[DW-1]};
        ge_s      = (r_shift_s >= {1'b0, d_r});
        if (ge_s) begin
            r_next_s = r_shift_s - {1'b0, d_r};
        end else begin
            r_next_s = r_shift_s;
        end
        q_next_s = {q_r[DW-2:0], ge_s};
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            q_r         <= {DW{1'b0}};
            d_r         <= {VW{1'b0}};
            r_r         <= {VW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {VW{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        q_r        <= dividend;
                        d_r        <= divisor;
                        r_r        <= {VW{1'b0}};
                        cnt_r      <= CW'(DW - 1);
                        in_ready_r <= 1'b0;
                        if (divisor == {VW{1'b0}}) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    q_r <= q_next_s;
                    r_r <= r_next_s[VW-1:0];
                    if (cnt_r == {CW{1'b0}}) begin
                        quotient_r  <= q_next_s;
                        remainder_r <= r_next_s[VW-1:0];
                        dbz_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_DONE: begin
                    // Entering DONE without a result means the divide-by-zero shortcut.
                    if (!out_valid_r) begin
                        quotient_r  <= {DW{1'b1}};
                        remainder_r <= {VW{1'b0}};
                        dbz_r       <= 1'b1;
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_prod_divider_seq.sv
`timescale 1ns/1ps
// Bench for prod_divider_seq: vector table, handshake/reset corner sequences and a random
// product-inversion sweep, all checked through an expected-result queue.
module tb_prod_divider_seq;

    localparam int DW = 17;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    prod_divider_seq #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dd;
        logic [VW-1:0] dv;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
    } vec_t;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
        int            lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, queue the expected result, present the op for exactly one accept edge.
    task automatic issue(input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                         input logic [DW-1:0] q, input logic [VW-1:0] r, input logic dbz);
        exp_t e;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick;
            w++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        e.q = q; e.r = r; e.dbz = dbz; e.lat = dbz ? 1 : DW;
        sb.push_back(e);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        check("busy_after_accept", 32'(in_ready), 32'd0);
    endtask

    // Wait for the result, compare with the queue head, optionally stall, then hand off.
    task automatic collect(input int hold);
        exp_t e;
        int k;
        k = 0;
        while (!out_valid && k < 40) begin
            tick;
            k++;
        end
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("latency", 32'(k), 32'(e.lat));
            check("quotient", 32'(quotient), 32'(e.q));
            check("remainder", 32'(remainder), 32'(e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                dividend = DW'($urandom);
                divisor  = VW'($urandom);
                tick;
                check("hold_stable", {3'b0, out_valid, in_ready, quotient, remainder, div_by_zero},
                      {3'b0, 1'b1, 1'b0, e.q, e.r, e.dbz});
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("handoff_valid_low", 32'(out_valid), 32'd0);
        check("handoff_ready_high", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] p;
        logic [DW-1:0] x;
        logic [VW-1:0] y;

        vecs[0] = '{17'd65025,  8'd255, 17'd255,    8'd0,  1'b0};
        vecs[1] = '{17'd100,    8'd7,   17'd14,     8'd2,  1'b0};
        vecs[2] = '{17'd131071, 8'd1,   17'd131071, 8'd0,  1'b0};
        vecs[3] = '{17'd1234,   8'd0,   17'h1FFFF,  8'd0,  1'b1};
        vecs[4] = '{17'd0,      8'd5,   17'd0,      8'd0,  1'b0};
        vecs[5] = '{17'd131071, 8'd255, 17'd514,    8'd1,  1'b0};
        vecs[6] = '{17'd1000,   8'd3,   17'd333,    8'd1,  1'b0};
        vecs[7] = '{17'd254,    8'd255, 17'd0,      8'd254, 1'b0};
        vecs[8] = '{17'd77,     8'd77,  17'd1,      8'd0,  1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) tick;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", {14'b0, quotient, remainder, div_by_zero}, 32'd0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].dbz);
            collect(0);
        end

        // Stalled consumer: result must hold and new requests must be ignored.
        issue(17'd500, 8'd7, 17'd71, 8'd3, 1'b0);
        collect(10);
        issue(17'd6, 8'd3, 17'd2, 8'd0, 1'b0);
        collect(0);

        // Reset mid-RUN discards the op and clears the outputs.
        issue(17'd1000, 8'd3, 17'd333, 8'd1, 1'b0);
        void'(sb.pop_back());
        repeat (7) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrun_rst_ready", 32'(in_ready), 32'd1);
        check("midrun_rst_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_outputs", {14'b0, quotient, remainder, div_by_zero}, 32'd0);
        repeat (20) tick;
        check("no_phantom_result", 32'(out_valid), 32'd0);
        issue(17'd255, 8'd16, 17'd15, 8'd15, 1'b0);
        collect(0);

        // Reset while a result waits in DONE.
        issue(17'd100, 8'd7, 17'd14, 8'd2, 1'b0);
        void'(sb.pop_back());
        repeat (DW) tick;
        check("done_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("done_rst_valid", 32'(out_valid), 32'd0);
        check("done_rst_ready", 32'(in_ready), 32'd1);

        // Exact products must invert to the other operand with zero remainder.
        for (int i = 0; i < 20; i++) begin
            x = DW'($urandom_range(0, 255));
            y = VW'($urandom_range(1, 255));
            p = x * DW'(y);
            issue(p, y, x, 8'd0, 1'b0);
            collect(0);
        end
        // Arbitrary dividends against a plain arithmetic reference.
        for (int i = 0; i < 8; i++) begin
            p = DW'($urandom_range(0, 131071));
            y = VW'($urandom_range(1, 255));
            issue(p, y, p / DW'(y), VW'(p % DW'(y)), 1'b0);
            collect(0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
